// File: rtl/led_matrix_pkg.sv
// Shared encodings for the LED matrix scan controller: FSM states, scan modes
// and the default dwell counter width.
package led_matrix_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DAC_START = 3'd1,
        DAC_WAIT  = 3'd2,
        DWELL     = 3'd3,
        ADVANCE   = 3'd4
    } scan_state_t;

    localparam logic MODE_RASTER     = 1'b0;
    localparam logic MODE_SERP       = 1'b1;
    localparam int   DWELL_W_DEFAULT = 16;

endpackage

// File: rtl/led_dwell_timer.sv
// Loadable down-counter that sets the per-pixel dwell. It stops at zero and
// raises zero_o there. A load request takes priority over a decrement.
module led_dwell_timer
    import led_matrix_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               en_i,
    output logic               zero_o
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row/column scan controller for the bolometer LED matrix (raster or serpentine).
// Define LED_SCAN_LOOP_EN to add loop_i, which makes scans repeat until abort.
module led_matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int DWELL_W = DWELL_W_DEFAULT,
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               mode_i,
    input  logic [DWELL_W-1:0] dwell_i,
`ifdef LED_SCAN_LOOP_EN
    input  logic               loop_i,
`endif
    input  logic               eodac_i,
    output logic               stdac_o,
    output logic               en_o,
    output logic [ROW_W-1:0]   row_o,
    output logic [COL_W-1:0]   col_o,
    output logic               busy_o,
    output logic               eos_o,
    output logic               done_o
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    scan_state_t        state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               done_q, done_d;
    logic               latch_cfg;
    logic               mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [DWELL_W-1:0] tmr_load_val;
    logic               row_reversed;
    logic [COL_W-1:0]   col_end, col_step, next_row_start;
    logic               last_pix;
`ifdef LED_SCAN_LOOP_EN
    logic               loop_q;
`endif

    // Odd rows run right-to-left only in serpentine mode.
    assign row_reversed   = (mode_q == MODE_SERP) && row_q[0];
    assign col_end        = row_reversed ? '0 : COL_LAST;
    assign col_step       = row_reversed ? (col_q - COL_W'(1)) : (col_q + COL_W'(1));
    assign next_row_start = ((mode_q == MODE_SERP) && !row_q[0]) ? COL_LAST : '0;
    assign last_pix       = (row_q == ROW_LAST) && (col_q == col_end);
    assign tmr_load_val   = (dwell_q == '0) ? '0 : (dwell_q - DWELL_W'(1));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        latch_cfg = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    latch_cfg = 1'b1;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = DAC_START;
                end
            end
            DAC_START: state_d = DAC_WAIT;
            DAC_WAIT: begin
                if (eodac_i) begin
                    tmr_load = 1'b1;
                    state_d  = DWELL;
                end
            end
            DWELL: begin
                if (tmr_zero) state_d = ADVANCE;
                else          tmr_dec = 1'b1;
            end
            ADVANCE: begin
                if (last_pix) begin
                    done_d = 1'b1;
                    row_d  = '0;
                    col_d  = '0;
`ifdef LED_SCAN_LOOP_EN
                    state_d = loop_q ? DAC_START : IDLE;
`else
                    state_d = IDLE;
`endif
                end else if (col_q == col_end) begin
                    row_d   = row_q + ROW_W'(1);
                    col_d   = next_row_start;
                    state_d = DAC_START;
                end else begin
                    col_d    = col_step;
                    tmr_load = 1'b1;
                    state_d  = DWELL;
                end
            end
            default: begin
                row_d   = '0;
                col_d   = '0;
                state_d = IDLE;
            end
        endcase
        // Abort overrides everything decided above.
        if (abort_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            row_d    = '0;
            col_d    = '0;
            done_d   = 1'b0;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch_cfg) begin
            mode_q  <= mode_i;
            dwell_q <= dwell_i;
`ifdef LED_SCAN_LOOP_EN
            loop_q  <= loop_i;
`endif
        end
    end

    led_dwell_timer #(
        .DWELL_W(DWELL_W)
    ) u_dwell_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .en_i      (tmr_dec),
        .zero_o    (tmr_zero)
    );

    assign stdac_o = (state_q == DAC_START);
    assign en_o    = (state_q == DWELL);
    assign busy_o  = (state_q != IDLE);
    assign eos_o   = (state_q == IDLE);
    assign done_o  = done_q;
    assign row_o   = row_q;
    assign col_o   = col_q;

endmodule
